// File: rtl/nf10_axis_rx_pkt_buffer.sv
// Store-and-forward RX frame buffer: commits whole frames only, tags each released frame with a
// length/port metadata word on tuser. Optional: define NF10_RX_BAD_FCS_DROP_EN to drop bad-FCS frames.
module nf10_axis_rx_pkt_buffer #(
    parameter int         C_AXIS_DATA_WIDTH  = 256,
    parameter int         C_AXIS_TUSER_WIDTH = 128,
    parameter int         C_DATA_DEPTH_LOG2  = 9,
    parameter int         C_META_DEPTH_LOG2  = 5,
    parameter logic [7:0] C_DEFAULT_SRC_PORT = 8'h01,
    parameter logic [7:0] C_DEFAULT_DST_PORT = 8'h00
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic [7:0]                      cfg_dst_port,
    output logic [31:0]                     pkt_count,
    output logic [31:0]                     drop_count,
    output logic [1:0]                      o_dbg_wr_state,
    output logic [1:0]                      o_dbg_rd_state
);

    // Handshake on both AXI4-Stream ports: a beat moves on a rising edge where tvalid && tready;
    // the master keeps tdata/tstrb/tuser/tlast stable while tvalid && !tready. The slave-side tready
    // only drops in reset, so the MAC is never stalled and overflow is handled by dropping frames.

    localparam int DW     = C_AXIS_DATA_WIDTH;
    localparam int SW     = C_AXIS_DATA_WIDTH / 8;
    localparam int DL     = C_DATA_DEPTH_LOG2;
    localparam int ML     = C_META_DEPTH_LOG2;
    localparam int DDEPTH = 1 << DL;
    localparam int MDEPTH = 1 << ML;
    localparam logic [DL-1:0] D_ONE = DL'(1);
    localparam logic [ML:0]   M_ONE = (ML + 1)'(1);
    localparam logic [ML+1:0] M_CAP = (ML + 2)'(MDEPTH);

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_HEAD, RD_BODY} rd_state_t;

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic               r_s_ready;
    logic [DL-1:0]      r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [ML:0]        r_meta_wr, r_meta_rd;
    logic [15:0]        r_len, r_commit_len, w_len_base, w_len_next;
    logic [16:0]        w_beat_bytes, w_len_sum;
    logic [7:0]         r_commit_dst;
    logic               r_commit_pending;
    logic [31:0]        r_pkt_count, r_drop_count;
    logic [DW+SW:0]     r_data_mem [DDEPTH];
    logic [31:0]        r_meta_mem [MDEPTH];

    logic               w_beat, w_data_full, w_meta_full, w_meta_empty, w_bad_fcs;
    logic [ML:0]        w_meta_count;
    logic [ML+1:0]      w_meta_level;
    logic               w_wr_en, w_rewind, w_commit, w_drop_evt;
    logic [DW+SW:0]     w_rd_word;
    logic               w_rd_valid, w_rd_hs, w_rd_last, w_rd_adv, w_meta_pop, w_more_pending;
    logic               w_unused_tuser;

`ifdef NF10_RX_BAD_FCS_DROP_EN
    assign w_bad_fcs      = s_axis_tuser[0];
    assign w_unused_tuser = &{1'b0, s_axis_tuser[C_AXIS_TUSER_WIDTH-1:1]};
`else
    assign w_bad_fcs      = 1'b0;
    assign w_unused_tuser = &{1'b0, s_axis_tuser};
`endif

    assign w_beat       = s_axis_tvalid & r_s_ready;
    assign w_data_full  = (r_wr_ptr + D_ONE) == r_rd_ptr;
    assign w_meta_count = r_meta_wr - r_meta_rd;
    assign w_meta_empty = (r_meta_wr == r_meta_rd);
    // A commit in flight already owns a metadata slot, so count it as occupied.
    assign w_meta_level = (ML + 2)'(w_meta_count) + (ML + 2)'(r_commit_pending);
    assign w_meta_full  = (w_meta_level >= M_CAP);

    always_comb begin
        w_beat_bytes = '0;
        for (int i = 0; i < SW; i++) begin
            w_beat_bytes = w_beat_bytes + 17'(s_axis_tstrb[i]);
        end
        w_len_base = (r_wr_state == WR_IDLE) ? 16'h0000 : r_len;
        w_len_sum  = {1'b0, w_len_base} + w_beat_bytes;
        w_len_next = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_en        = 1'b0;
        w_rewind       = 1'b0;
        w_commit       = 1'b0;
        w_drop_evt     = 1'b0;
        case (r_wr_state)
            WR_IDLE: if (w_beat) begin
                if (w_meta_full || w_data_full) begin
                    if (s_axis_tlast) w_drop_evt = 1'b1;
                    else              w_wr_state_nxt = WR_DROP;
                end else if (s_axis_tlast && w_bad_fcs) begin
                    w_drop_evt = 1'b1;
                end else begin
                    w_wr_en = 1'b1;
                    if (s_axis_tlast) w_commit = 1'b1;
                    else              w_wr_state_nxt = WR_PKT;
                end
            end
            WR_PKT: if (w_beat) begin
                if (w_data_full || (s_axis_tlast && w_bad_fcs)) begin
                    w_rewind = 1'b1;
                    if (s_axis_tlast) begin
                        w_drop_evt     = 1'b1;
                        w_wr_state_nxt = WR_IDLE;
                    end else begin
                        w_wr_state_nxt = WR_DROP;
                    end
                end else begin
                    w_wr_en = 1'b1;
                    if (s_axis_tlast) begin
                        w_commit       = 1'b1;
                        w_wr_state_nxt = WR_IDLE;
                    end
                end
            end
            WR_DROP: if (w_beat && s_axis_tlast) begin
                w_drop_evt     = 1'b1;
                w_wr_state_nxt = WR_IDLE;
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    assign w_rd_valid     = (r_rd_state != RD_IDLE);
    assign w_rd_word      = r_data_mem[r_rd_ptr];
    assign w_rd_last      = w_rd_word[DW+SW];
    assign w_rd_hs        = w_rd_valid & m_axis_tready;
    // A commit landing this cycle counts as pending so frames stream out without a gap.
    assign w_more_pending = (w_meta_count > M_ONE) || r_commit_pending;

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_adv       = 1'b0;
        w_meta_pop     = 1'b0;
        case (r_rd_state)
            RD_IDLE: if (!w_meta_empty) w_rd_state_nxt = RD_HEAD;
            RD_HEAD, RD_BODY: if (w_rd_hs) begin
                w_rd_adv = 1'b1;
                if (w_rd_last) begin
                    w_meta_pop     = 1'b1;
                    w_rd_state_nxt = w_more_pending ? RD_HEAD : RD_IDLE;
                end else begin
                    w_rd_state_nxt = RD_BODY;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_s_ready        <= 1'b0;
            r_wr_state       <= WR_IDLE;
            r_rd_state       <= RD_IDLE;
            r_wr_ptr         <= '0;
            r_wr_commit      <= '0;
            r_rd_ptr         <= '0;
            r_meta_wr        <= '0;
            r_meta_rd        <= '0;
            r_len            <= '0;
            r_commit_len     <= '0;
            r_commit_dst     <= C_DEFAULT_DST_PORT;
            r_commit_pending <= 1'b0;
            r_pkt_count      <= '0;
            r_drop_count     <= '0;
        end else begin
            r_s_ready        <= 1'b1;
            r_wr_state       <= w_wr_state_nxt;
            r_rd_state       <= w_rd_state_nxt;
            r_commit_pending <= w_commit;
            if (w_rewind)     r_wr_ptr <= r_wr_commit;
            else if (w_wr_en) r_wr_ptr <= r_wr_ptr + D_ONE;
            if (w_wr_en)      r_len    <= w_len_next;
            if (w_commit) begin
                r_commit_len <= w_len_next;
                r_commit_dst <= cfg_dst_port;
            end
            if (r_commit_pending) begin
                r_wr_commit <= r_wr_ptr;
                r_meta_wr   <= r_meta_wr + M_ONE;
                if (r_pkt_count != 32'hFFFF_FFFF) r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_drop_evt && (r_drop_count != 32'hFFFF_FFFF)) r_drop_count <= r_drop_count + 32'd1;
            if (w_rd_adv)   r_rd_ptr  <= r_rd_ptr + D_ONE;
            if (w_meta_pop) r_meta_rd <= r_meta_rd + M_ONE;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (w_wr_en) r_data_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
        if (r_commit_pending) r_meta_mem[r_meta_wr[ML-1:0]] <= {r_commit_dst, C_DEFAULT_SRC_PORT, r_commit_len};
    end

    always_comb begin
        m_axis_tvalid = w_rd_valid;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        if (w_rd_valid) begin
            m_axis_tdata = w_rd_word[DW-1:0];
            m_axis_tstrb = w_rd_word[DW+SW-1:DW];
            m_axis_tlast = w_rd_last;
        end
        if (r_rd_state == RD_HEAD) m_axis_tuser[31:0] = r_meta_mem[r_meta_rd[ML-1:0]];
    end

    assign s_axis_tready  = r_s_ready;
    assign pkt_count      = r_pkt_count;
    assign drop_count     = r_drop_count;
    assign o_dbg_wr_state = r_wr_state;
    assign o_dbg_rd_state = r_rd_state;

endmodule
